// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-buffer geometry defaults and scheduler state encoding
package fb_pkg;

   localparam int FB_X_WIDTH = 10;
   localparam int FB_Y_WIDTH = 9;
   localparam int FB_X_MAX   = 639;
   localparam int FB_Y_MAX   = 479;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } fb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, one-hot output
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   // a lone requester wins; on a tie the one not granted last wins
   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - arbitrates two pixel requesters and full-frame clear onto one write port
module fb_write_scheduler
   import fb_pkg::*;
#(
   parameter int X_WIDTH = FB_X_WIDTH,
   parameter int Y_WIDTH = FB_Y_WIDTH,
   parameter int X_MAX   = FB_X_MAX,
   parameter int Y_MAX   = FB_Y_MAX
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_start,
   output logic                       clear_busy,
   input  logic                       req0_valid,
   input  logic [X_WIDTH-1:0]         req0_x,
   input  logic [Y_WIDTH-1:0]         req0_y,
   input  logic                       req0_data,
   output logic                       req0_ready,
   input  logic                       req1_valid,
   input  logic [X_WIDTH-1:0]         req1_x,
   input  logic [Y_WIDTH-1:0]         req1_y,
   input  logic                       req1_data,
   output logic                       req1_ready,
   output logic                       fb_we,
   output logic [X_WIDTH+Y_WIDTH-1:0] fb_wr_addr,
   output logic                       fb_wr_data
);

   localparam logic [X_WIDTH-1:0] XM = X_WIDTH'(X_MAX);
   localparam logic [Y_WIDTH-1:0] YM = Y_WIDTH'(Y_MAX);

   fb_state_e                  state_q, state_d;
   logic                       last_q, last_d;   // 1: requester 1 was granted last
   logic [X_WIDTH-1:0]         cx_q, cx_d;       // clear address now on the fb port
   logic [Y_WIDTH-1:0]         cy_q, cy_d;
   logic                       we_d;
   logic [X_WIDTH+Y_WIDTH-1:0] addr_d;
   logic                       data_d;
   logic [1:0]                 valid, grant, ready;
   logic [X_WIDTH-1:0]         sel_x;
   logic [Y_WIDTH-1:0]         sel_y;
   logic                       sel_data;

   assign valid = {req1_valid, req0_valid};

   rr_arb2 u_arb (
      .valid (valid),
      .last  (last_q),
      .grant (grant)
   );

   assign sel_x      = grant[1] ? req1_x    : req0_x;
   assign sel_y      = grant[1] ? req1_y    : req0_y;
   assign sel_data   = grant[1] ? req1_data : req0_data;
   assign req0_ready = ready[0];
   assign req1_ready = ready[1];
   assign clear_busy = (state_q == CLEAR);

   // next state, grant/ready and the next fb write; clear_start beats any pixel
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      we_d    = 1'b0;
      addr_d  = fb_wr_addr;
      data_d  = fb_wr_data;
      ready   = 2'b00;
      case (state_q)
         ARB: begin
            if (clear_start) begin
               state_d = CLEAR;
               cx_d    = '0;
               cy_d    = '0;
               we_d    = 1'b1;
               addr_d  = '0;
               data_d  = 1'b0;
            end else begin
               ready = rst_n ? grant : 2'b00;
               if (|grant) begin
                  last_d = grant[1];
                  if (sel_x <= XM && sel_y <= YM) begin
                     we_d   = 1'b1;
                     addr_d = {sel_x, sel_y};
                     data_d = sel_data;
                  end
               end
            end
         end
         CLEAR: begin
            if (cx_q == XM && cy_q == YM) begin
               state_d = ARB;
            end else begin
               if (cy_q == YM) begin
                  cy_d = '0;
                  cx_d = cx_q + 1'b1;
               end else begin
                  cy_d = cy_q + 1'b1;
               end
               we_d   = 1'b1;
               addr_d = {cx_d, cy_d};
               data_d = 1'b0;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // state, pointer, clear counters and registered fb port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ARB;
         last_q     <= 1'b1;
         cx_q       <= '0;
         cy_q       <= '0;
         fb_we      <= 1'b0;
         fb_wr_addr <= '0;
         fb_wr_data <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         fb_we      <= we_d;
         fb_wr_addr <= addr_d;
         fb_wr_data <= data_d;
      end
   end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - randomized and directed checks against a frame-level model
module tb_fb_write_scheduler;

   localparam int XW = 10;
   localparam int YW = 9;
   localparam int XM = 19;
   localparam int YM = 11;
   localparam int NPIX = (XM + 1) * (YM + 1);

   logic          clk;
   logic          rst_n;
   logic          clear_start;
   logic          clear_busy;
   logic          req0_valid, req0_data, req0_ready;
   logic [XW-1:0] req0_x;
   logic [YW-1:0] req0_y;
   logic          req1_valid, req1_data, req1_ready;
   logic [XW-1:0] req1_x;
   logic [YW-1:0] req1_y;
   logic          fb_we;
   logic [XW+YW-1:0] fb_wr_addr;
   logic          fb_wr_data;

   int            n_vec = 0;
   int            n_err = 0;

   bit            m_busy, m_last, m_we, m_data, m_chk;
   logic [XW+YW-1:0] m_addr;
   int            m_k;

   fb_write_scheduler #(
      .X_WIDTH (XW),
      .Y_WIDTH (YW),
      .X_MAX   (XM),
      .Y_MAX   (YM)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .req0_valid  (req0_valid),
      .req0_x      (req0_x),
      .req0_y      (req0_y),
      .req0_data   (req0_data),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_x      (req1_x),
      .req1_y      (req1_y),
      .req1_data   (req1_data),
      .req1_ready  (req1_ready),
      .fb_we       (fb_we),
      .fb_wr_addr  (fb_wr_addr),
      .fb_wr_data  (fb_wr_data)
   );

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [XW+YW-1:0] clear_addr(input int k);
      int x, y;
      x = k / (YM + 1);
      y = k % (YM + 1);
      return {x[XW-1:0], y[YW-1:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one cycle: compare at mid-cycle, then advance the model across the rising edge
   task automatic step();
      logic [1:0] v, g;
      int         sx, sy;
      bit         sd;
      #4;
      v = {req1_valid, req0_valid};
      if (!rst_n || m_busy || clear_start) g = 2'b00;
      else if (v == 2'b11)                 g = m_last ? 2'b01 : 2'b10;
      else                                 g = v;
      check("req0_ready", req0_ready, g[0]);
      check("req1_ready", req1_ready, g[1]);
      check("clear_busy", clear_busy, m_busy);
      check("fb_we", fb_we, m_we);
      if (m_we || m_chk) begin
         check("fb_wr_addr", fb_wr_addr, m_addr);
         check("fb_wr_data", fb_wr_data, m_data);
      end
      m_chk = 1'b0;
      if (!rst_n) begin
         m_busy = 1'b0; m_last = 1'b1; m_we = 1'b0;
         m_addr = '0;   m_data = 1'b0; m_chk = 1'b1;
      end else if (m_busy) begin
         if (m_k == NPIX - 1) begin
            m_busy = 1'b0;
            m_we   = 1'b0;
         end else begin
            m_k++;
            m_we   = 1'b1;
            m_addr = clear_addr(m_k);
            m_data = 1'b0;
         end
      end else if (clear_start) begin
         m_busy = 1'b1; m_k = 0; m_we = 1'b1;
         m_addr = clear_addr(0); m_data = 1'b0;
      end else if (g != 2'b00) begin
         m_last = g[1];
         sx = g[1] ? int'(req1_x) : int'(req0_x);
         sy = g[1] ? int'(req1_y) : int'(req0_y);
         sd = g[1] ? req1_data : req0_data;
         if (sx <= XM && sy <= YM) begin
            m_we   = 1'b1;
            m_addr = {sx[XW-1:0], sy[YW-1:0]};
            m_data = sd;
         end else begin
            m_we = 1'b0;
         end
      end else begin
         m_we = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_req();
      req0_valid = 1'($urandom_range(0, 1));
      req0_x     = XW'($urandom_range(0, XM + 2));
      req0_y     = YW'($urandom_range(0, YM + 2));
      req0_data  = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req1_x     = XW'($urandom_range(0, XM + 2));
      req1_y     = YW'($urandom_range(0, YM + 2));
      req1_data  = 1'($urandom_range(0, 1));
   endtask

   task automatic set_req0(input bit v, input int x, input int y, input bit d);
      req0_valid = v; req0_x = XW'(x); req0_y = YW'(y); req0_data = d;
   endtask

   task automatic set_req1(input bit v, input int x, input int y, input bit d);
      req1_valid = v; req1_x = XW'(x); req1_y = YW'(y); req1_data = d;
   endtask

   // directed sequence followed by a randomized run
   initial begin
      rst_n = 1'b0;
      clear_start = 1'b0;
      set_req0(0, 0, 0, 0);
      set_req1(0, 0, 0, 0);
      m_busy = 1'b0; m_last = 1'b1; m_we = 1'b0; m_addr = '0; m_data = 1'b0;
      m_chk = 1'b1; m_k = 0;
      @(posedge clk);
      #1;
      set_req0(1, 2, 3, 1);
      set_req1(1, 4, 5, 1);
      step();
      step();
      set_req0(0, 0, 0, 0);
      set_req1(0, 0, 0, 0);
      rst_n = 1'b1;
      step();

      set_req0(1, 5, 7, 1);
      step();
      set_req0(0, 0, 0, 0);
      step();
      step();

      set_req0(1, 1, 2, 1);
      set_req1(1, 3, 4, 0);
      repeat (4) step();
      set_req0(0, 0, 0, 0);
      set_req1(0, 0, 0, 0);
      step();

      set_req1(1, XM + 1, 10, 1);
      step();
      set_req1(1, XM, YM + 1, 1);
      step();
      set_req1(1, XM, YM, 1);
      step();
      set_req1(0, 0, 0, 0);
      step();

      set_req0(1, 3, 4, 1);
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      repeat (50) step();
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      repeat (NPIX) step();
      set_req0(0, 0, 0, 0);
      step();

      set_req1(1, 6, 6, 1);
      step();
      set_req1(0, 0, 0, 0);
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      repeat (NPIX + 2) step();

      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      repeat (100) step();
      rst_n = 1'b0;
      rand_req();
      step();
      rst_n = 1'b1;
      repeat (5) begin
         rand_req();
         step();
      end

      repeat (1500) begin
         rand_req();
         clear_start = ($urandom_range(0, 399) == 0);
         step();
      end
      clear_start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
